// File: rtl/nn_config_sequencer_if.sv
// rtl/nn_config_sequencer_if.sv - config word stream in, shared layer weight/bias bus out
interface nn_config_sequencer_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [DATA_W-1:0] biasValue;
   logic              biasValid;
   logic [DATA_W-1:0] weightValue;
   logic              weightValid;
   logic [DATA_W-1:0] config_layer_num;
   logic [DATA_W-1:0] config_neuron_num;

   modport master (
      output cfg_data, cfg_valid,
      input  cfg_ready,
      input  biasValue, biasValid, weightValue, weightValid,
      input  config_layer_num, config_neuron_num
   );

   modport slave (
      input  cfg_data, cfg_valid,
      output cfg_ready,
      output biasValue, biasValid, weightValue, weightValid,
      output config_layer_num, config_neuron_num
   );
endinterface

// File: rtl/nn_config_sequencer.sv
// rtl/nn_config_sequencer.sv - walks layer/neuron/weight counters over a flat bias+weight stream
// Optional trailing checksum word enabled by CFG_CHECKSUM_EN.
module nn_config_sequencer #(
   parameter int DATA_W = 32,
   parameter int N1     = 30,
   parameter int N2     = 30,
   parameter int N3     = 10,
   parameter int W1     = 784,
   parameter int W2     = 30,
   parameter int W3     = 30
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   nn_config_sequencer_if.slave cfg_if,
   output logic busy,
   output logic done,
   output logic infer_en,
   output logic cfg_error
);

   localparam int W_MAX = (W1 > W2) ? ((W1 > W3) ? W1 : W3) : ((W2 > W3) ? W2 : W3);
   localparam int N_MAX = (N1 > N2) ? ((N1 > N3) ? N1 : N3) : ((N2 > N3) ? N2 : N3);
   localparam int WC_W  = $clog2(W_MAX + 1);
   localparam int NC_W  = $clog2(N_MAX + 1);

`ifdef CFG_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, BIAS, WEIGHT, NEXT, CHECK, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, BIAS, WEIGHT, NEXT, DONE} state_t;
`endif

   state_t            state_q, state_d;
   logic [1:0]        layer_q, layer_d;
   logic [NC_W-1:0]   neuron_q, neuron_d;
   logic [WC_W-1:0]   wcnt_q, wcnt_d;
   logic [DATA_W-1:0] bias_value_q, bias_value_d;
   logic [DATA_W-1:0] weight_value_q, weight_value_d;
   logic              bias_valid_q, bias_valid_d;
   logic              weight_valid_q, weight_valid_d;
   logic              infer_en_q, infer_en_d;
   logic              ready;
   logic              hs;
   logic [WC_W-1:0]   w_last;
   logic [NC_W-1:0]   n_last;
`ifdef CFG_CHECKSUM_EN
   logic [31:0]       sum_q, sum_d;
   logic              cfg_error_q, cfg_error_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         layer_q        <= 2'd1;
         neuron_q       <= '0;
         wcnt_q         <= '0;
         bias_value_q   <= '0;
         weight_value_q <= '0;
         bias_valid_q   <= 1'b0;
         weight_valid_q <= 1'b0;
         infer_en_q     <= 1'b0;
`ifdef CFG_CHECKSUM_EN
         sum_q          <= '0;
         cfg_error_q    <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         layer_q        <= layer_d;
         neuron_q       <= neuron_d;
         wcnt_q         <= wcnt_d;
         bias_value_q   <= bias_value_d;
         weight_value_q <= weight_value_d;
         bias_valid_q   <= bias_valid_d;
         weight_valid_q <= weight_valid_d;
         infer_en_q     <= infer_en_d;
`ifdef CFG_CHECKSUM_EN
         sum_q          <= sum_d;
         cfg_error_q    <= cfg_error_d;
`endif
      end
   end

   // Last weight index and last neuron index of the layer being loaded.
   always_comb begin
      w_last = WC_W'(W3 - 1);
      n_last = NC_W'(N3 - 1);
      case (layer_q)
         2'd1: begin
            w_last = WC_W'(W1 - 1);
            n_last = NC_W'(N1 - 1);
         end
         2'd2: begin
            w_last = WC_W'(W2 - 1);
            n_last = NC_W'(N2 - 1);
         end
         default: ;
      endcase
   end

`ifdef CFG_CHECKSUM_EN
   assign ready = (state_q == BIAS) || (state_q == WEIGHT) || (state_q == CHECK);
`else
   assign ready = (state_q == BIAS) || (state_q == WEIGHT);
`endif
   assign hs = cfg_if.cfg_valid & ready;

   always_comb begin
      state_d        = state_q;
      layer_d        = layer_q;
      neuron_d       = neuron_q;
      wcnt_d         = wcnt_q;
      bias_value_d   = bias_value_q;
      weight_value_d = weight_value_q;
      bias_valid_d   = 1'b0;
      weight_valid_d = 1'b0;
      infer_en_d     = infer_en_q;
      done           = 1'b0;
`ifdef CFG_CHECKSUM_EN
      sum_d          = sum_q;
      cfg_error_d    = cfg_error_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = BIAS;
               layer_d    = 2'd1;
               neuron_d   = '0;
               wcnt_d     = '0;
               infer_en_d = 1'b0;
`ifdef CFG_CHECKSUM_EN
               sum_d       = '0;
               cfg_error_d = 1'b0;
`endif
            end
         end
         BIAS: begin
            if (hs) begin
               bias_valid_d = 1'b1;
               bias_value_d = cfg_if.cfg_data;
               state_d      = WEIGHT;
`ifdef CFG_CHECKSUM_EN
               sum_d = sum_q + 32'(cfg_if.cfg_data);
`endif
            end
         end
         WEIGHT: begin
            if (hs) begin
               weight_valid_d = 1'b1;
               weight_value_d = cfg_if.cfg_data;
`ifdef CFG_CHECKSUM_EN
               sum_d = sum_q + 32'(cfg_if.cfg_data);
`endif
               if (wcnt_q == w_last) begin
                  wcnt_d  = '0;
                  state_d = NEXT;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         // Config numbers only move here, after the last weight strobe has gone out.
         NEXT: begin
            if (neuron_q != n_last) begin
               neuron_d = neuron_q + 1'b1;
               state_d  = BIAS;
            end else if (layer_q != 2'd3) begin
               layer_d  = layer_q + 2'd1;
               neuron_d = '0;
               state_d  = BIAS;
            end else begin
`ifdef CFG_CHECKSUM_EN
               state_d = CHECK;
`else
               state_d    = DONE;
               infer_en_d = 1'b1;
`endif
            end
         end
`ifdef CFG_CHECKSUM_EN
         // infer_en is settled on entry to DONE so it rises together with done.
         CHECK: begin
            if (hs) begin
               state_d = DONE;
               if (32'(cfg_if.cfg_data) != sum_q) begin
                  cfg_error_d = 1'b1;
                  infer_en_d  = 1'b0;
               end else begin
                  infer_en_d = 1'b1;
               end
            end
         end
`endif
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy                     = (state_q != IDLE);
   assign infer_en                 = infer_en_q;
`ifdef CFG_CHECKSUM_EN
   assign cfg_error                = cfg_error_q;
`else
   assign cfg_error                = 1'b0;
`endif
   assign cfg_if.cfg_ready         = ready;
   assign cfg_if.biasValue         = bias_value_q;
   assign cfg_if.biasValid         = bias_valid_q;
   assign cfg_if.weightValue       = weight_value_q;
   assign cfg_if.weightValid       = weight_valid_q;
   assign cfg_if.config_layer_num  = DATA_W'(layer_q);
   assign cfg_if.config_neuron_num = DATA_W'(neuron_q);

endmodule

// File: tb/tb_nn_config_sequencer.sv
// tb/tb_nn_config_sequencer.sv - directed bench for nn_config_sequencer with a small network
module tb_nn_config_sequencer;

   localparam int N1 = 2, W1 = 3, N2 = 2, W2 = 2, N3 = 1, W3 = 2;
   localparam int NWORDS = 17;
   localparam int NBIAS = 5;
   localparam int NWEIGHT = 12;
`ifdef CFG_CHECKSUM_EN
   localparam int EXTRA = 1;
   localparam int LAT = 1;
`else
   localparam int EXTRA = 0;
   localparam int LAT = 2;
`endif

   logic clk;
   logic rst;
   logic start;
   logic busy, done, infer_en, cfg_error;

   nn_config_sequencer_if #(.DATA_W(32)) bus ();

   nn_config_sequencer #(
      .DATA_W(32), .N1(N1), .N2(N2), .N3(N3), .W1(W1), .W2(W2), .W3(W3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .cfg_if   (bus),
      .busy     (busy),
      .done     (done),
      .infer_en (infer_en),
      .cfg_error(cfg_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Expected per-word view of the stream: kind (1 = bias), layer, neuron, last weight of its neuron.
   logic exp_kind [1:NWORDS];
   logic exp_last [1:NWORDS];
   int   exp_layer [1:NWORDS];
   int   exp_neuron [1:NWORDS];
   int   exp_bias [NBIAS] = '{1, 5, 9, 12, 15};

   int   exp_idx, bias_cnt, weight_cnt, done_cnt, done_cyc, last_hs_cyc;
   logic infer_at_done;
   logic prev_hs = 1'b0;
   int   bias_seen [NBIAS];

   initial begin
      int w;
      int nl, wl;
      w = 0;
      for (int l = 1; l <= 3; l++) begin
         nl = (l == 1) ? N1 : (l == 2) ? N2 : N3;
         wl = (l == 1) ? W1 : (l == 2) ? W2 : W3;
         for (int n = 0; n < nl; n++) begin
            w++;
            exp_kind[w] = 1'b1; exp_last[w] = 1'b0; exp_layer[w] = l; exp_neuron[w] = n;
            for (int k = 0; k < wl; k++) begin
               w++;
               exp_kind[w] = 1'b0; exp_last[w] = (k == wl - 1);
               exp_layer[w] = l; exp_neuron[w] = n;
            end
         end
      end
   end

   initial begin
      int wi;
      logic [31:0] val;
      forever begin
         @(negedge clk);
         #1;
         if (bus.biasValid || bus.weightValid) begin
            check("strobe_after_hs", 32'(prev_hs), 1);
            if (exp_idx < NWORDS) begin
               wi = exp_idx + 1;
               val = bus.biasValid ? bus.biasValue : bus.weightValue;
               check("strobe_both", 32'(bus.biasValid & bus.weightValid), 0);
               check("strobe_kind", 32'(bus.biasValid), 32'(exp_kind[wi]));
               check("strobe_value", val, 32'(wi));
               check("layer_num", bus.config_layer_num, 32'(exp_layer[wi]));
               check("neuron_num", bus.config_neuron_num, 32'(exp_neuron[wi]));
               if (!exp_kind[wi] && exp_last[wi]) check("ready_in_next", 32'(bus.cfg_ready), 0);
               if (bus.biasValid) begin
                  if (bias_cnt < NBIAS) bias_seen[bias_cnt] = val;
                  bias_cnt++;
               end else begin
                  weight_cnt++;
               end
            end else begin
               check("extra_strobe", 32'(exp_idx), NWORDS - 1);
            end
            exp_idx++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            infer_at_done = infer_en;
         end
         prev_hs = bus.cfg_valid & bus.cfg_ready;
      end
   end

   task automatic run_load(input bit toggle, input int glitch_w, input int abort_w,
                           input logic [31:0] chk_word, input bit exp_err);
      int w, guard, phase, n;
      logic v;
      n = NWORDS + EXTRA;
      exp_idx = 0; bias_cnt = 0; weight_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -100;
      @(negedge clk);
      start = 1'b1;
      bus.cfg_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", 32'(busy), 1);
      check("start_infer_clr", 32'(infer_en), 0);
      check("start_err_clr", 32'(cfg_error), 0);
      w = 1; guard = 0; phase = 0;
      while (w <= n && guard < 400) begin
         if (abort_w != 0 && w > abort_w) break;
         start = 1'b0;
         v = toggle ? (phase % 2 == 0) : 1'b1;
         phase++;
         bus.cfg_valid = v;
         bus.cfg_data = (w <= NWORDS) ? 32'(w) : chk_word;
         if (v && bus.cfg_ready) begin
            if (w == glitch_w) start = 1'b1;
            last_hs_cyc = cyc;
            w++;
         end
         guard++;
         @(negedge clk);
      end
      bus.cfg_valid = 1'b0;
      start = 1'b0;
      if (abort_w != 0) return;
      check("words_accepted", 32'(w - 1), 32'(n));
      for (int i = 0; i < 8; i++) @(negedge clk);
      #2;
      check("bias_count", 32'(bias_cnt), NBIAS);
      check("weight_count", 32'(weight_cnt), NWEIGHT);
      for (int i = 0; i < NBIAS; i++) check("bias_value", bias_seen[i], 32'(exp_bias[i]));
      check("done_count", 32'(done_cnt), 1);
      check("done_latency", 32'(done_cyc - last_hs_cyc), LAT);
      check("infer_at_done", 32'(infer_at_done), 32'(!exp_err));
      check("infer_level", 32'(infer_en), 32'(!exp_err));
      check("cfg_error", 32'(cfg_error), 32'(exp_err));
      check("idle_busy", 32'(busy), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      bus.cfg_valid = 1'b0; bus.cfg_data = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus.cfg_ready), 0);
      check("rst_bias_valid", 32'(bus.biasValid), 0);
      check("rst_weight_valid", 32'(bus.weightValid), 0);
      check("rst_bias_value", bus.biasValue, 0);
      check("rst_weight_value", bus.weightValue, 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_infer", 32'(infer_en), 0);
      check("rst_err", 32'(cfg_error), 0);
      check("rst_layer", bus.config_layer_num, 1);
      check("rst_neuron", bus.config_neuron_num, 0);
      rst = 1'b0;

      run_load(1'b0, 0, 0, 32'd153, 1'b0);
      run_load(1'b1, 0, 0, 32'd153, 1'b0);
      run_load(1'b0, 6, 0, 32'd153, 1'b0);

      run_load(1'b0, 0, 10, 32'd153, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_infer", 32'(infer_en), 0);
      check("abort_layer", bus.config_layer_num, 1);
      check("abort_neuron", bus.config_neuron_num, 0);
      check("abort_ready", 32'(bus.cfg_ready), 0);
      run_load(1'b0, 0, 0, 32'd153, 1'b0);

      @(negedge clk);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check("rst_beats_start", 32'(busy), 0);
      check("rst_clears_infer", 32'(infer_en), 0);

`ifdef CFG_CHECKSUM_EN
      run_load(1'b0, 0, 0, 32'd154, 1'b1);
      run_load(1'b1, 0, 0, 32'd153, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
